csr_trap_seq: RTL
=================

CSR_TRAP_SEQ -- requirements
Module: csr_trap_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, CSR data width.
REQ-002 SHALL have parameter CSRADDR_WIDTH, default 12, CSR address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports: clk (input, 1, rising-edge clock), rst_n (input, 1, async active-low reset).
REQ-004 SHALL have port trap_req, input, 1 bit: ecall/exception request, held until redirect_valid.
REQ-005 SHALL have port mret_req, input, 1 bit: mret request, held until redirect_valid.
REQ-006 SHALL have port trap_pc, input, DATA_WIDTH bits: PC of the trapping instruction.
REQ-007 SHALL have port trap_cause, input, DATA_WIDTH bits: mcause value.
REQ-008 SHALL have port trap_tval, input, DATA_WIDTH bits: mtval value.
REQ-009 SHALL have port rcsaddr, output, CSRADDR_WIDTH bits: CSR read address to the register file.
REQ-010 SHALL have port rcsdata, input, DATA_WIDTH bits: combinational CSR read data.
REQ-011 SHALL have port csr_wen, output, 1 bit: CSR write strobe.
REQ-012 SHALL have port wcsaddr, output, CSRADDR_WIDTH bits: CSR write address.
REQ-013 SHALL have port wcsdata, output, DATA_WIDTH bits: CSR write data.
REQ-014 SHALL have port busy, output, 1 bit: sequence in progress; the core stalls while it is high.
REQ-015 SHALL have port redirect_valid, output, 1 bit: one-cycle pulse that completes a sequence.
REQ-016 SHALL have port redirect_pc, output, DATA_WIDTH bits: new fetch PC, valid with redirect_valid.

Function
REQ-017 SHALL implement FSM states IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTAT, R_MSTAT, REDIR.
REQ-018 SHALL, in IDLE with trap_req=1, capture trap_pc/trap_cause/trap_tval and a kind flag (trap), then go to T_MEPC.
REQ-019 SHALL, in IDLE with mret_req=1 and trap_req=0, set kind=mret and go to R_MSTAT.
REQ-020 SHALL give trap_req priority when both requests are high in IDLE; mret_req is ignored that cycle.
REQ-021 SHALL ignore both requests in every state other than IDLE.
REQ-022 SHALL step the trap path one state per cycle: T_MEPC writes 0x341=pc; T_MCAUSE writes 0x342=cause; T_MTVAL writes 0x343=tval; T_MSTAT writes 0x300; then REDIR.
REQ-023 SHALL, in T_MSTAT, drive rcsaddr=0x300 and write rcsdata with MPIE(bit 7)=old MIE(bit 3), MIE=0, and MPP(bits 12:11)=2'b11; all other bits are unchanged.
REQ-024 SHALL, in R_MSTAT, drive rcsaddr=0x300 and write rcsdata with MIE=old MPIE, MPIE=1, and MPP=2'b11; then go to REDIR.
REQ-025 SHALL, in REDIR, drive rcsaddr=0x305 (mtvec) for a trap or 0x341 (mepc) for an mret, pulse redirect_valid, and set redirect_pc=rcsdata with bits 1:0 cleared; the next state is IDLE.
REQ-026 SHALL assert csr_wen only in T_MEPC, T_MCAUSE, T_MTVAL, T_MSTAT and R_MSTAT; one write per cycle.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL, in IDLE, drive rcsaddr=0, wcsaddr=0 and wcsdata=0.
REQ-029 SHALL decode csr_wen, wcsaddr, busy and redirect_valid from the state register only, with no combinational path from trap_req or mret_req.
REQ-030 SHALL have a latency from trap acceptance to redirect_valid of 5 cycles (4 without mtval); mret latency SHALL be 2 cycles.
REQ-031 SHALL accept a request in IDLE in the cycle after REDIR, so back-to-back sequences have no bubble beyond IDLE.

Reset
REQ-032 SHALL, on rst_n=0, immediately enter IDLE, clear the capture registers, and force csr_wen=0, busy=0, redirect_valid=0 and redirect_pc=0.
REQ-033 SHALL abort any partial sequence on reset mid-operation without completing the remaining CSR writes.

Configuration
REQ-034 SHALL define macro CSR_TRAP_SEQ_MTVAL_EN: when defined, T_MTVAL exists; when undefined, T_MCAUSE goes directly to T_MSTAT, trap_tval is unused, and trap latency is 4.

Structure
REQ-035 SHALL place the CSR address constants (0x300, 0x305, 0x341, 0x342, 0x343), the mstatus bit positions and the state enum typedef in the shared package csr_pkg.
REQ-036 SHALL implement the mstatus rewrite in one combinational sub-module, mstatus_upd, with inputs old value and kind, and output new value.

Verification
REQ-037 SHALL cover: trap_req, pc=0x80000010, cause=11, mtvec=0x80000100 -> writes mepc=0x80000010, mcause=11, mtval, mstatus; redirect_pc=0x80000100 at cycle 5.
REQ-038 SHALL cover: mstatus=0x00000008 before trap -> written mstatus=0x00001880.
REQ-039 SHALL cover: mret with mstatus=0x00001880 and mepc=0x80000014 -> mstatus=0x00001888, redirect_pc=0x80000014 at cycle 2.
REQ-040 SHALL cover: trap_req and mret_req both high in IDLE -> trap path taken; no mret write occurs.
REQ-041 SHALL cover: rst_n low in T_MCAUSE -> busy=0 and csr_wen=0 immediately; no mstatus write; IDLE after release.
REQ-042 SHALL cover: build without CSR_TRAP_SEQ_MTVAL_EN -> no write to 0x343, redirect at cycle 4.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, mstatus bit positions and sequencer types shared by the trap sequencer.
package csr_pkg;
    localparam int CSR_MSTATUS = 'h300;
    localparam int CSR_MTVEC   = 'h305;
    localparam int CSR_MEPC    = 'h341;
    localparam int CSR_MCAUSE  = 'h342;
    localparam int CSR_MTVAL   = 'h343;
    localparam int MST_MIE     = 3;
    localparam int MST_MPIE    = 7;
    localparam int MST_MPP_LO  = 11;
    localparam int MST_MPP_HI  = 12;
    typedef enum logic [2:0] {IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTAT, R_MSTAT, REDIR} state_e;
    typedef enum logic {K_TRAP, K_MRET} kind_e;
endpackage

// File: rtl/mstatus_upd.sv
// mstatus_upd: combinational mstatus rewrite for trap entry (i_kind=0) and mret (i_kind=1).
module mstatus_upd import csr_pkg::*; #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic                  i_kind,
    output logic [DATA_WIDTH-1:0] o_new
);
    always_comb begin
        o_new = i_old;
        o_new[MST_MIE] = i_kind ? i_old[MST_MPIE] : 1'b0;
        o_new[MST_MPIE] = i_kind ? 1'b1 : i_old[MST_MIE];
        o_new[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    end
endmodule

// File: rtl/csr_trap_seq.sv
// csr_trap_seq: sequences trap-entry / mret CSR updates and the fetch redirect.
// Define CSR_TRAP_SEQ_MTVAL_EN to add the mtval write step to the trap path.
module csr_trap_seq import csr_pkg::*; #(
    parameter int DATA_WIDTH    = 64,
    parameter int CSRADDR_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trap_req,
    input  logic                     mret_req,
    input  logic [DATA_WIDTH-1:0]    trap_pc,
    input  logic [DATA_WIDTH-1:0]    trap_cause,
    input  logic [DATA_WIDTH-1:0]    trap_tval,
    output logic [CSRADDR_WIDTH-1:0] rcsaddr,
    input  logic [DATA_WIDTH-1:0]    rcsdata,
    output logic                     csr_wen,
    output logic [CSRADDR_WIDTH-1:0] wcsaddr,
    output logic [DATA_WIDTH-1:0]    wcsdata,
    output logic                     busy,
    output logic                     redirect_valid,
    output logic [DATA_WIDTH-1:0]    redirect_pc
);
    state_e                r_state;
    kind_e                 r_kind;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_cause;
    logic [DATA_WIDTH-1:0] w_tval;
    logic [DATA_WIDTH-1:0] w_mstat_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_kind  <= K_TRAP;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trap_req) begin
                        r_kind  <= K_TRAP;
                        r_pc    <= trap_pc;
                        r_cause <= trap_cause;
                        r_state <= T_MEPC;
                    end else if (mret_req) begin
                        r_kind  <= K_MRET;
                        r_state <= R_MSTAT;
                    end
                end
                T_MEPC: r_state <= T_MCAUSE;
`ifdef CSR_TRAP_SEQ_MTVAL_EN
                T_MCAUSE: r_state <= T_MTVAL;
`else
                T_MCAUSE: r_state <= T_MSTAT;
`endif
                T_MTVAL: r_state <= T_MSTAT;
                T_MSTAT, R_MSTAT: r_state <= REDIR;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CSR_TRAP_SEQ_MTVAL_EN
    logic [DATA_WIDTH-1:0] r_tval;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tval <= '0;
        else if (r_state == IDLE && trap_req)
            r_tval <= trap_tval;
    end
    assign w_tval = r_tval;
`else
    logic w_unused_tval;
    assign w_unused_tval = ^trap_tval;
    assign w_tval = '0;
`endif

    mstatus_upd #(.DATA_WIDTH(DATA_WIDTH)) u_mstatus_upd (
        .i_old  (rcsdata),
        .i_kind (r_kind == K_MRET),
        .o_new  (w_mstat_new)
    );

    // Outputs depend on the state register only, so requests never reach them combinationally.
    assign busy           = r_state != IDLE;
    assign redirect_valid = r_state == REDIR;
    assign csr_wen        = busy && !redirect_valid;
    assign redirect_pc    = redirect_valid ? {rcsdata[DATA_WIDTH-1:2], 2'b00} : '0;
    assign rcsaddr        = (r_state == T_MSTAT || r_state == R_MSTAT) ? CSRADDR_WIDTH'(CSR_MSTATUS) :
                            !redirect_valid ? '0 :
                            r_kind == K_MRET ? CSRADDR_WIDTH'(CSR_MEPC) : CSRADDR_WIDTH'(CSR_MTVEC);

    always_comb begin
        wcsaddr = '0;
        wcsdata = '0;
        case (r_state)
            T_MEPC: begin
                wcsaddr = CSRADDR_WIDTH'(CSR_MEPC);
                wcsdata = r_pc;
            end
            T_MCAUSE: begin
                wcsaddr = CSRADDR_WIDTH'(CSR_MCAUSE);
                wcsdata = r_cause;
            end
            T_MTVAL: begin
                wcsaddr = CSRADDR_WIDTH'(CSR_MTVAL);
                wcsdata = w_tval;
            end
            T_MSTAT, R_MSTAT: begin
                wcsaddr = CSRADDR_WIDTH'(CSR_MSTATUS);
                wcsdata = w_mstat_new;
            end
            default: ;
        endcase
    end
endmodule
